// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream loader: load-state encoding
// and the element-counter width function.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } load_state_e;

    // ceil(log2(n)), at least 1, so a counter can index n slots.
    function automatic int count_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// Collects a row-major element stream into an NxN matrix and holds it until
// the determinant stage consumes it. Define MATRIX_LOADER_ABORT_EN to add the abort input.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
`ifdef MATRIX_LOADER_ABORT_EN
    input  logic                                      abort,
`endif
    input  logic [DATA_WIDTH-1:0]                     in_data,
    input  logic                                      in_valid,
    input  logic                                      in_last,
    output logic                                      in_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix,
    output logic                                      mat_valid,
    input  logic                                      mat_ready,
    output logic                                      err
);

    localparam int NUM_ELEMS = MATRIX_SIZE * MATRIX_SIZE;
    localparam int CW        = count_width(NUM_ELEMS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_ELEMS - 1);

    // BIN_POS only travels with the data; it is sanity-checked, never used in arithmetic.
    if (MATRIX_SIZE < 2 || MATRIX_SIZE > 8 || BIN_POS < 0 || BIN_POS > DATA_WIDTH) begin : g_cfg_check
        $error("matrix_stream_loader: illegal MATRIX_SIZE or BIN_POS");
    end

    load_state_e           state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  mat_valid_q, mat_valid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [NUM_ELEMS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_ELEMS];
    logic                  accept;

    // Ready depends on state alone, but is forced low while reset is held.
    assign in_ready  = ~rst & (state_q != FULL);
    assign accept    = in_valid & in_ready;
    assign mat_valid = mat_valid_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mat_valid_d = mat_valid_q;
        err_d       = 1'b0;
        mem_d       = mem_q;

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    mem_d[count_q] = in_data;
                    if (count_q == LAST_IDX) begin
                        // A missing in_last still completes the matrix, but is flagged.
                        state_d     = FULL;
                        count_d     = '0;
                        mat_valid_d = 1'b1;
                        err_d       = ~in_last;
                    end else if (in_last) begin
                        state_d = IDLE;
                        count_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = FILL;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (mat_ready) begin
                    state_d     = IDLE;
                    count_d     = '0;
                    mat_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                count_d     = '0;
                mat_valid_d = 1'b0;
            end
        endcase

`ifdef MATRIX_LOADER_ABORT_EN
        // Abort wins over a same-cycle accept or consume and is not an error.
        if (abort) begin
            state_d     = IDLE;
            count_d     = '0;
            mat_valid_d = 1'b0;
            err_d       = 1'b0;
            mem_d       = mem_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mat_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mat_valid_q <= mat_valid_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_flatten
        assign matrix[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[gi];
    end

endmodule
